// File: rtl/freq_meter.sv
// freq_meter: gated rising-edge counter reporting sig_in edges per GATE_CYCLES clk window
// Ports: clk, reset (async, active-high), sig_in (async input under measurement),
//   start (request, sampled in IDLE), busy (measurement in progress),
//   done (1-cycle pulse on result update), freq (edge count), overflow (count saturated)
// FREQ_METER_CONT_EN: when defined, gates repeat back-to-back after the first start
module freq_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] freq,
  output logic             overflow
);
  typedef enum logic [1:0] {IDLE, MEAS, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] sync_q, sync_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d, freq_q, freq_d;
  logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
  logic sat_q, sat_d, busy_q, busy_d, done_q, done_d, overflow_q, overflow_d;
  logic rise;
  // sync_q[1:0] is the 2-FF synchronizer, sync_q[2] the previous-value register
  assign sync_d = {sync_q[1:0], sig_in};
  assign rise = sync_q[1] & ~sync_q[2];
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    gate_cnt_d = gate_cnt_q;
    sat_d      = sat_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    freq_d     = freq_q;
    overflow_d = overflow_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d    = MEAS;
        edge_cnt_d = '0;
        gate_cnt_d = '0;
        sat_d      = 1'b0;
        busy_d     = 1'b1;
      end
      MEAS: begin
        gate_cnt_d = gate_cnt_q + 1'b1;
        // saturate instead of wrapping; the extra edge is remembered in sat
        if (rise) begin
          if (&edge_cnt_q) sat_d = 1'b1;
          else edge_cnt_d = edge_cnt_q + 1'b1;
        end
        if (gate_cnt_q == GATE_W'(GATE_CYCLES - 1)) state_d = DONE;
      end
      DONE: begin
        freq_d     = edge_cnt_q;
        overflow_d = sat_q;
        done_d     = 1'b1;
`ifdef FREQ_METER_CONT_EN
        state_d    = MEAS;
        edge_cnt_d = '0;
        gate_cnt_d = '0;
        sat_d      = 1'b0;
`else
        state_d    = IDLE;
        busy_d     = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      edge_cnt_q <= '0;
      gate_cnt_q <= '0;
      sat_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      freq_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      edge_cnt_q <= edge_cnt_d;
      gate_cnt_q <= gate_cnt_d;
      sat_q      <= sat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      freq_q     <= freq_d;
      overflow_q <= overflow_d;
    end
  end
  assign busy     = busy_q;
  assign done     = done_q;
  assign freq     = freq_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed self-checking bench for freq_meter with a 100-cycle gate and 4-bit count
module tb_freq_meter;
  localparam int GC = 100;
  localparam int CW = 4;
  logic clk = 1'b0, reset = 1'b1, sig_in = 1'b0, start = 1'b0;
  logic busy, done, overflow;
  logic [CW-1:0] freq;
  int n_chk = 0, n_fail = 0, period = 0, ph = 0, cyc = 0, bcnt = 0, dcnt = 0;
  freq_meter #(.GATE_CYCLES(GC), .CNT_W(CW), .GATE_W(8)) dut (
    .clk(clk), .reset(reset), .sig_in(sig_in), .start(start),
    .busy(busy), .done(done), .freq(freq), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  // advance to the next falling edge; a nonzero period drives a 50% square wave
  task automatic step();
    @(negedge clk);
    if (period != 0) begin
      ph = (ph + 1) % period;
      sig_in = (ph < period / 2);
    end
  endtask
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  // cyc counts falling edges since the start-accepting edge, bounded at 400
  task automatic wait_done(input int c0);
    cyc = c0;
    bcnt = int'(busy);
    while (!done && cyc < 400) begin
      step();
      cyc++;
      if (busy) bcnt++;
    end
  endtask
  task automatic measure(input int p, input int ef, input int eo);
    period = p;
    repeat (40) step();
    do_start();
    wait_done(0);
    check($sformatf("p%0d_done_cyc", p), cyc, 101);
    check($sformatf("p%0d_freq", p), freq, ef);
    check($sformatf("p%0d_ovf", p), overflow, eo);
  endtask
  initial begin
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_freq", freq, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b0;
    step();
`ifdef FREQ_METER_CONT_EN
    measure(10, 10, 0);
    check("cont_busy0", busy, 1);
    repeat (2) begin
      step();
      wait_done(1);
      check("cont_period", cyc, 101);
      check("cont_freq", freq, 10);
      check("cont_busy", busy, 1);
    end
`else
    period = 10;
    repeat (40) step();
    do_start();
    check("busy_after_start", busy, 1);
    wait_done(0);
    check("p10_done_cyc", cyc, 101);
    check("p10_busy_cycles", bcnt, 101);
    check("p10_freq", freq, 10);
    check("p10_ovf", overflow, 0);
    check("p10_busy_at_done", busy, 0);
    step();
    check("done_one_cycle", done, 0);
    do_start();
    repeat (40) step();
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_freq", freq, 0);
    check("abort_ovf", overflow, 0);
    step();
    reset = 1'b0;
    dcnt = 0;
    repeat (150) begin
      step();
      if (done) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    check("abort_stays_idle", busy, 0);
    period = 0;
    sig_in = 1'b0;
    repeat (10) step();
    do_start();
    repeat (50) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(51);
    check("restart_ignored_cyc", cyc, 101);
    check("zero_freq", freq, 0);
    check("zero_ovf", overflow, 0);
    measure(4, 15, 1);
    measure(20, 5, 0);
    repeat (10) step();
    check("freq_hold", freq, 5);
    check("ovf_hold", overflow, 0);
    period = 0;
    sig_in = 1'b0;
    repeat (10) step();
    start = 1'b1;
    step();
    repeat (97) step();
    sig_in = 1'b1;
    step();
    sig_in = 1'b0;
    step();
    sig_in = 1'b1;
    step();
    step();
    check("last_cycle_done", done, 1);
    check("last_cycle_rise", freq, 1);
    check("last_cycle_ovf", overflow, 0);
    step();
    start = 1'b0;
    check("held_start_rearm", busy, 1);
    wait_done(0);
    check("rearm_done_cyc", cyc, 101);
    check("idle_rise_dropped", freq, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
